// File: rtl/channel_fifo_pkg.sv
// Shared definitions for the channel FIFO: the occupancy-update decode used by the top level.
package channel_fifo_pkg;

  localparam int DEPTH_MIN = 2;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // Simultaneous push and pop leave occupancy unchanged.
  function automatic cnt_op_e count_op(input logic push, input logic pop);
    cnt_op_e op;
    op = CNT_HOLD;
    if (push && !pop) op = CNT_INC;
    else if (pop && !push) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/channel_fifo_ring_ptr.sv
// Circular index register: wraps from Depth-1 back to 0, so Depth need not be a power of two.
module ring_ptr #(
  parameter int Depth = 4,
  parameter int PtrW  = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [PtrW-1:0] ptr
);

  localparam logic [PtrW-1:0] LAST = PtrW'(Depth - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PtrW'(1);
    end
  end

endmodule

// File: rtl/channel_fifo.sv
// Elastic buffer between two valid/acknowledge channels; handshakes depend only on registered occupancy.
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int N      = 1,
  parameter int Depth  = 4,
  parameter int CountW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_d,
  input  logic              in_v,
  output logic              in_a,
  output logic [N-1:0]      out_d,
  output logic              out_v,
  input  logic              out_a,
  output logic [CountW-1:0] count
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [CountW-1:0] FULL = CountW'(Depth);

  logic [N-1:0]    mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic            push;
  logic            pop;

  assign in_a  = (count != FULL);
  assign out_v = (count != '0);
  assign push  = in_v && in_a;
  assign pop   = out_v && out_a;
  assign out_d = mem[rd_ptr];

  ring_ptr #(.Depth(Depth), .PtrW(PtrW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  ring_ptr #(.Depth(Depth), .PtrW(PtrW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  // Storage carries no reset; stale contents are hidden by out_v.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case (count_op(push, pop))
        CNT_INC: count <= count + CountW'(1);
        CNT_DEC: count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_depth_min:   assert property (@(posedge clk) Depth >= DEPTH_MIN);
  a_count_max:   assert property (@(posedge clk) disable iff (reset) count <= FULL);
  a_push_full:   assert property (@(posedge clk) disable iff (reset) !(push && count == FULL));
  a_pop_empty:   assert property (@(posedge clk) disable iff (reset) !(pop && count == '0));
  a_in_d_known:  assert property (@(posedge clk) disable iff (reset) push |-> !$isunknown(in_d));
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Scoreboard bench: directed sequences on a 4-deep FIFO and randomized-timing traffic on a 3-deep one.
module tb_channel_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, Depth=4
  logic       reset_a = 1'b1;
  logic [3:0] a_in_d = '0;
  logic       a_in_v = 1'b0;
  logic       a_in_a;
  logic [3:0] a_out_d;
  logic       a_out_v;
  logic       a_out_a = 1'b0;
  logic [2:0] a_count;

  // Instance B: N=8, Depth=3
  logic       reset_b = 1'b1;
  logic [7:0] b_in_d = '0;
  logic       b_in_v = 1'b0;
  logic       b_in_a;
  logic [7:0] b_out_d;
  logic       b_out_v;
  logic       b_out_a = 1'b0;
  logic [1:0] b_count;

  channel_fifo #(.N(4), .Depth(4)) dut_a (
    .clk(clk), .reset(reset_a), .in_d(a_in_d), .in_v(a_in_v), .in_a(a_in_a),
    .out_d(a_out_d), .out_v(a_out_v), .out_a(a_out_a), .count(a_count)
  );

  channel_fifo #(.N(8), .Depth(3)) dut_b (
    .clk(clk), .reset(reset_b), .in_d(b_in_d), .in_v(b_in_v), .in_a(b_in_a),
    .out_d(b_out_d), .out_v(b_out_v), .out_a(b_out_a), .count(b_count)
  );

  int checks = 0;
  int failures = 0;
  int b_rcv = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: compare every observed pop against the head of the expected queue
  always @(negedge clk) begin
    if (!reset_a && a_out_v && a_out_a) begin
      if (qa.size() == 0) chk("a_unexpected_word", {28'd0, a_out_d}, 32'hFFFF_FFFF);
      else chk("a_out_d", {28'd0, a_out_d}, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset_b) begin
      chk("b_count_le_depth", {31'd0, (b_count <= 2'd3)}, 32'd1);
      if (b_out_v && b_out_a) begin
        if (qb.size() == 0) chk("b_unexpected_word", {24'd0, b_out_d}, 32'hFFFF_FFFF);
        else chk("b_out_d", {24'd0, b_out_d}, qb.pop_front());
        b_rcv++;
      end
    end
  end

  task automatic seq_a();
    #7 reset_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_in_a", a_in_a, 1);
      chk("idle_out_v", a_out_v, 0);
      chk("idle_count", a_count, 0);
    end
    @(posedge clk); #1;
    // Fill to full with the sink stalled
    for (int k = 1; k <= 4; k++) begin
      a_in_v = 1'b1; a_in_d = 4'(k); qa.push_back(8'(k));
      @(posedge clk); #1;
      chk("fill_count", a_count, k);
    end
    chk("full_in_a", a_in_a, 0);
    a_in_d = 4'd5;
    repeat (2) begin @(posedge clk); #1; end
    chk("full_hold_count", a_count, 4);
    chk("full_hold_in_a", a_in_a, 0);
    // Drain
    a_in_v = 1'b0; a_out_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("drain_count", a_count, 4 - k);
      if (k == 1) chk("drain_in_a_rise", a_in_a, 1);
    end
    chk("drain_out_v", a_out_v, 0);
    chk("drain_in_a", a_in_a, 1);
    // Full-rate stream
    for (int i = 0; i < 16; i++) begin
      a_in_v = 1'b1; a_in_d = 4'(i); qa.push_back(8'(i));
      @(posedge clk); #1;
      chk("stream_out_v", a_out_v, 1);
      chk("stream_count", a_count, 1);
    end
    a_in_v = 1'b0;
    @(posedge clk); #1;
    chk("stream_end_count", a_count, 0);
    chk("stream_queue_empty", qa.size(), 0);
    // Asynchronous reset mid-operation
    a_out_a = 1'b0;
    for (int k = 7; k <= 8; k++) begin
      a_in_v = 1'b1; a_in_d = 4'(k);
      @(posedge clk); #1;
    end
    chk("pre_reset_count", a_count, 2);
    a_in_d = 4'd6;
    #2 reset_a = 1'b1;
    #1;
    chk("rst_out_v", a_out_v, 0);
    chk("rst_in_a", a_in_a, 1);
    chk("rst_count", a_count, 0);
    a_in_v = 1'b0;
    @(posedge clk); #3 reset_a = 1'b0;
    @(posedge clk); #1;
    a_in_v = 1'b1; a_in_d = 4'd9; qa.push_back(8'd9);
    @(posedge clk); #1;
    a_in_v = 1'b0; a_out_a = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_reset_queue_empty", qa.size(), 0);
    chk("post_reset_count", a_count, 0);
  endtask

  task automatic drive_b();
    int d;
    int guard;
    logic [7:0] v;
    #7 reset_b = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 200; w++) begin
      d = $urandom_range(0, 5);
      v = 8'($urandom);
      repeat (d) begin @(posedge clk); #1; end
      b_in_v = 1'b1; b_in_d = v; qb.push_back(v);
      guard = 0;
      @(negedge clk);
      while (!b_in_a && guard < 100) begin @(negedge clk); guard++; end
      if (guard >= 100) chk("b_in_a_timeout", 0, 1);
      @(posedge clk); #1;
      b_in_v = 1'b0;
    end
  endtask

  task automatic sink_b();
    int cyc = 0;
    int d;
    #7;
    @(posedge clk); #1;
    while (b_rcv < 200 && cyc < 20000) begin
      d = $urandom_range(0, 5);
      b_out_a = 1'b0;
      repeat (d) begin @(posedge clk); #1; cyc++; end
      b_out_a = 1'b1;
      @(negedge clk);
      while (!b_out_v && cyc < 20000) begin @(negedge clk); cyc++; end
      @(posedge clk); #1; cyc++;
    end
    b_out_a = 1'b0;
    if (cyc >= 20000) chk("b_sink_timeout", 0, 1);
  endtask

  initial begin
    #1;
    chk("reset_in_a", a_in_a, 1);
    chk("reset_out_v", a_out_v, 0);
    chk("reset_count", a_count, 0);
    fork
      seq_a();
      drive_b();
      sink_b();
    join
    chk("b_received", b_rcv, 200);
    chk("b_queue_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/channel_fifo.md
Name: channel_fifo

Overview:
- Elastic buffer between two valid/data-acknowledge Channels.
- Accepts words from an upstream sender and stores up to Depth of them. Re-presents them in order to a downstream consumer.
- Placed directly downstream of a ChannelSender-driven producer. Decouples producer timing from a sink that stalls for arbitrary cycles.
- Sustains one transfer per cycle on each side simultaneously.

Parameters:
- N, 1, data width in bits.
- Depth, 4, number of storage entries; must be at least 2; need not be a power of two.
- CountW, $clog2(Depth+1), width of the occupancy output (derived; not overridden).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- in_d  input  N  upstream data (Channel in.d).
- in_v  input  1  upstream valid (in.v).
- in_a  output  1  upstream acknowledge (in.a).
- out_d  output  N  downstream data (Channel out.d).
- out_v  output  1  downstream valid (out.v).
- out_a  input  1  downstream acknowledge (out.a).
- count  output  CountW  current occupancy, 0..Depth.

Behaviour:
- Transfer rule: a transfer on a side occurs at a posedge where that side's v and a are both 1 (push = in_v&in_a, pop = out_v&out_a).
- in_a = (count != Depth).
  - Pure function of registered state; never depends on in_v.
  - No combinational path from in_v to in_a.
- out_v = (count != 0).
  - Pure function of registered state; never depends on out_a.
- out_d = mem[rd_ptr], combinational read of the head entry.
  - Value is undefined when out_v=0; the bench must not check it then.
  - While out_v=1 and no pop occurs, out_d is stable.
- Reset (async assert, any cycle, mid-transfer included):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Therefore out_v=0 and in_a=1 immediately.
  - Memory contents are not cleared.
  - Any transfer coincident with reset assertion is discarded.
- Push: mem[wr_ptr] <= in_d; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: a pointer equal to Depth-1 advances to 0; otherwise +1. Do not use modulo-2^k wrap.
- count update per posedge:
  - push&!pop: +1.
  - pop&!push: -1.
  - both or neither: unchanged.
- Latency: a word pushed into an empty FIFO appears with out_v=1 in the cycle after the push posedge. There is no bypass path.
- Full: in_a=0, so no push, even if a pop occurs in the same cycle. in_a rises the cycle after the pop.
- Empty: out_v=0, so no pop. A simultaneous push simply makes count=1.
- Simultaneous push and pop with 0<count<Depth: both pointers advance; count is held.
- Ordering: strictly FIFO; no word is lost or duplicated.
- Throughput:
  - With count in 1..Depth-1, one push and one pop are both possible per cycle.
  - A continuous stream with out_a held at 1 passes at full rate after one cycle of fill latency.
- Assertions (simulation only):
  - count never exceeds Depth.
  - A push never occurs while count==Depth.
  - A pop never occurs while count==0.
  - in_d must be known (no X) on a push.

Decomposition:
- Shared channel package: no new typedefs required. Ports are bundled as the existing Channel #(N) interface at the top level (in, out). The flat names above are member references.
- One natural sub-module: ring_ptr #(Depth).
  - Registered pointer with async reset to 0, increment enable, and wrap at Depth-1.
  - Instantiated twice (read and write).
- Storage is an unpacked array of Depth x N registers inside channel_fifo.

Test Plan:
- Reset then idle, N=4, Depth=4: after reset deassert, in_a=1, out_v=0, count=0, and these hold for 10 cycles with in_v=0.
- Fill to full, out_a=0: push 1,2,3,4 on consecutive cycles.
  - count steps 1,2,3,4; in_a=0 after the 4th push.
  - A 5th word (5) held valid is not accepted; count stays 4.
- Drain, in_v=0, out_a=1 from full: out_d reads 1,2,3,4 on consecutive cycles; out_v=0 and count=0 after the 4th pop.
- Full-rate stream, out_a=1, in_v=1 continuously, data 0..15:
  - out_v=1 starting the cycle after the first push.
  - Sink sees 0..15 in order, one per cycle; count stays 1.
- Wrap and non-power-of-two, Depth=3:
  - Random RandomChannelSrc/ChannelSink-style timing with delays 0..5, 200 words.
  - The received sequence equals the sent sequence; count never exceeds 3; pointers wrap 2->0.
- Reset mid-operation: with count=2 and a push pending, assert reset asynchronously between edges.
  - out_v=0, in_a=1 and count=0 before the next posedge.
  - After release, a new word 9 is the first word delivered.
